// File: rtl/apb4_sram_slave.sv
// APB4 SRAM completer: parametrised width/depth, programmable wait states,
// byte-lane write strobes and SLVERR for misaligned or out-of-range accesses.
module apb4_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IW    = ADDR_WIDTH - LSB;
    localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             cap_write, cap_err;
    logic [MW-1:0]    cap_idx;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [BYTES-1:0] cap_strb;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]    idx;
    logic             misaligned, err, setup, wr_en;

    assign idx = paddr[ADDR_WIDTH-1:LSB];

    // Byte-wide buses have no sub-word offset, so they can never be misaligned.
    generate
        if (LSB == 0) begin : g_no_align
            assign misaligned = 1'b0;
        end else begin : g_align
            assign misaligned = |paddr[LSB-1:0];
        end
    endgenerate

    assign err     = misaligned || ({1'b0, idx} >= (IW+1)'(DEPTH));
    assign setup   = (state == IDLE) && psel && !penable;
    assign pready  = (state == ACCESS) && (cnt == 4'd0) && psel && penable;
    assign pslverr = pready && cap_err;
    assign wr_en   = pready && cap_write && !cap_err;

    // State and wait counter registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: SETUP enters ACCESS, wait states count down, dropped psel aborts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_nxt = IDLE;
                end else if (penable) begin
                    if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SETUP-cycle capture; read data is fetched here so ACCESS-phase bus changes are ignored.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            prdata    <= '0;
        end else if (setup) begin
            cap_write <= pwrite;
            cap_err   <= err;
            cap_idx   <= idx[MW-1:0];
            cap_wdata <= pwdata;
            cap_strb  <= pstrb;
            if (!pwrite) prdata <= err ? '0 : mem[idx[MW-1:0]];
        end
    end

    // Storage array, written per byte lane on an error-free write completion.
    always_ff @(posedge pclk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (wr_en && cap_strb[i]) mem[cap_idx][i*8 +: 8] <= cap_wdata[i*8 +: 8];
        end
    end
endmodule

// File: tb/tb_apb4_sram_slave.sv
// Bench for apb4_sram_slave: three instances (1, 0 and 3 wait states) share one
// bus; a selector routes psel and picks which instance's outputs are observed.
module tb_apb4_sram_slave;
    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    int          dsel;

    logic [2:0]  psel_v;
    logic [31:0] prdata_a [3];
    logic [2:0]  pready_a, pslverr_a;
    logic [31:0] rdo;
    logic        rdy, erro;

    int checks = 0;
    int failures = 0;
    localparam int WS_T [3] = '{1, 0, 3};

    always #5 pclk = ~pclk;

    assign psel_v[0] = psel && (dsel == 0);
    assign psel_v[1] = psel && (dsel == 1);
    assign psel_v[2] = psel && (dsel == 2);
    assign rdo  = prdata_a[dsel];
    assign rdy  = pready_a[dsel];
    assign erro = pslverr_a[dsel];

    apb4_sram_slave #(.WAIT_STATES(1)) u_ws1 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]));
    apb4_sram_slave #(.WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]));
    apb4_sram_slave #(.WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a[2]), .pready(pready_a[2]), .pslverr(pslverr_a[2]));

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          eerr;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        bit          wr;
        bit          err;
        logic [31:0] rd;
    } exp_t;

    vec_t vt [15];
    exp_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One APB transfer; the ACCESS phase scrambles address/data to show they are ignored.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output bit er, output int cyc);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        rd = 'x; er = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b1; paddr = ~a; pwdata = ~d;
        cyc = 2;
        forever begin
            @(negedge pclk);
            if (rdy === 1'b1) begin
                rd = rdo; er = erro;
                break;
            end
            cyc++;
            if (cyc > 40) begin
                cyc = -1;
                break;
            end
            @(posedge pclk); #1;
        end
        @(posedge pclk); #1;
    endtask

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, mdl [16];
        bit er, seen;
        int cyc;

        vt[0]  = '{1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0};
        vt[1]  = '{0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF};
        vt[2]  = '{1, 32'h20,  32'h11223344, 4'hF, 0, 32'h0};
        vt[3]  = '{1, 32'h20,  32'hAABBCCDD, 4'h5, 0, 32'h0};
        vt[4]  = '{0, 32'h20,  32'h0,        4'h0, 0, 32'h11BB33DD};
        vt[5]  = '{1, 32'h400, 32'h12121212, 4'hF, 1, 32'h0};
        vt[6]  = '{1, 32'h13,  32'h34343434, 4'hF, 1, 32'h0};
        vt[7]  = '{0, 32'h13,  32'h0,        4'h0, 1, 32'h0};
        vt[8]  = '{0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF};
        vt[9]  = '{1, 32'h10,  32'h55555555, 4'h0, 0, 32'h0};
        vt[10] = '{0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF};
        vt[11] = '{1, 32'h3FC, 32'h12345678, 4'hF, 0, 32'h0};
        vt[12] = '{0, 32'h3FC, 32'h0,        4'h0, 0, 32'h12345678};
        vt[13] = '{0, 32'h401, 32'h0,        4'h0, 1, 32'h0};
        vt[14] = '{0, 32'h20,  32'h0,        4'h0, 0, 32'h11BB33DD};

        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; dsel = 0;

        // Reset values on every instance.
        repeat (2) @(negedge pclk);
        for (int k = 0; k < 3; k++) begin
            dsel = k; #1;
            chk($sformatf("reset_prdata%0d", k), rdo, 32'h0);
            chk($sformatf("reset_pready%0d", k), {31'h0, rdy}, 32'h0);
            chk($sformatf("reset_pslverr%0d", k), {31'h0, erro}, 32'h0);
        end
        dsel = 0;
        @(posedge pclk); #1 presetn = 1'b1;
        @(posedge pclk); #1;

        // Vector table on the 1-wait-state instance, issued back to back.
        for (int i = 0; i < 15; i++) begin
            xfer(vt[i].wr, vt[i].a, vt[i].d, vt[i].s, rd, er, cyc);
            chk($sformatf("vec%0d_cycles", i), cyc, 32'd3);
            chk($sformatf("vec%0d_pslverr", i), {31'h0, er}, {31'h0, vt[i].eerr});
            if (!vt[i].wr) chk($sformatf("vec%0d_prdata", i), rd, vt[i].erd);
        end
        bus_idle();

        // Abort: psel dropped in the first ACCESS cycle of a write to 0x30.
        xfer(1, 32'h30, 32'h0BADF00D, 4'hF, rd, er, cyc);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h99999999; pstrb = 4'hF;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            if (rdy !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_pready", {31'h0, seen}, 32'h0);
        penable = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 32'h30, 32'h0, 4'h0, rd, er, cyc);
        chk("abort_no_write", rd, 32'h0BADF00D);
        chk("abort_next_cycles", cyc, 32'd3);

        // penable without a SETUP is ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h0; pstrb = 4'hF;
        seen = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            if (rdy !== 1'b0) seen = 1'b1;
        end
        chk("proto_no_pready", {31'h0, seen}, 32'h0);
        @(posedge pclk); #1;
        xfer(0, 32'h30, 32'h0, 4'h0, rd, er, cyc);
        chk("proto_no_write", rd, 32'h0BADF00D);
        bus_idle();

        // Random back-to-back traffic against a scoreboard on each instance.
        for (int k = 0; k < 3; k++) begin
            dsel = k;
            for (int i = 0; i < 16; i++) begin
                mdl[i] = $urandom;
                xfer(1, 32'h100 + 32'(i*4), mdl[i], 4'hF, rd, er, cyc);
                chk($sformatf("init%0d_err", k), {31'h0, er}, 32'h0);
            end
            for (int n = 0; n < 30; n++) begin
                logic [31:0] a, d;
                logic [3:0] s;
                int ix, r;
                bit w, e;
                exp_t x, g;
                ix = $urandom_range(0, 15);
                r  = $urandom_range(0, 9);
                w  = 1'($urandom_range(0, 1));
                d  = $urandom;
                s  = 4'($urandom_range(0, 15));
                e  = (r <= 1);
                if (r == 0)      a = 32'h100 + 32'(ix*4) + 32'($urandom_range(1, 3));
                else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
                else             a = 32'h100 + 32'(ix*4);
                x.wr = w; x.err = e;
                x.rd = (w || e) ? 32'h0 : mdl[ix];
                exp_q.push_back(x);
                if (w && !e)
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mdl[ix][b*8 +: 8] = d[b*8 +: 8];
                xfer(w, a, d, s, rd, er, cyc);
                g = exp_q.pop_front();
                chk($sformatf("rnd%0d_%0d_cycles", k, n), cyc, 32'(2 + WS_T[k]));
                chk($sformatf("rnd%0d_%0d_err", k, n), {31'h0, er}, {31'h0, g.err});
                if (!g.wr) chk($sformatf("rnd%0d_%0d_rdata", k, n), rd, g.rd);
            end
            bus_idle();
        end

        // Reset asserted while a zero-wait read is completing.
        dsel = 1;
        xfer(1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er, cyc);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("prerst_pready", {31'h0, rdy}, 32'h1);
        chk("prerst_prdata", rdo, 32'hCAFEF00D);
        #1 presetn = 1'b0;
        #1;
        chk("midrst_pready", {31'h0, rdy}, 32'h0);
        chk("midrst_prdata", rdo, 32'h0);
        chk("midrst_pslverr", {31'h0, erro}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        chk("postrst_prdata", rd, 32'hCAFEF00D);
        chk("postrst_cycles", cyc, 32'd2);
        chk("postrst_err", {31'h0, er}, 32'h0);
        bus_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb4_sram_slave.md
# apb4_sram_slave

Parametrised APB4 memory slave, the next generation of the APB RAM target: configurable data width, depth and wait-state count, byte-lane write strobes, and error response for misaligned or out-of-range addresses. It sits on the APB bus as a single-select completer and is driven by the existing APB interface and bench environment, with `pstrb` added to that interface.

## Interface
- `ADDR_WIDTH`, default 32: width of `paddr`; byte address.
- `DATA_WIDTH`, default 32: width of `pwdata`/`prdata`; must be 8, 16, 32 or 64.
- `DEPTH`, default 256: number of `DATA_WIDTH` words.
- `WAIT_STATES`, default 1: extra ACCESS cycles before `pready`; 0 to 15.
- `pclk`  in  1  bus clock; everything on the rising edge.
- `presetn`  in  1  asynchronous, active-low reset.
- `psel`  in  1  slave select.
- `penable`  in  1  ACCESS phase marker.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  DATA_WIDTH  write data.
- `pstrb`  in  DATA_WIDTH/8  write byte-lane enables; ignored on reads.
- `prdata`  out  DATA_WIDTH  read data; valid only when `pready`=1 on a read.
- `pready`  out  1  transfer completes this cycle.
- `pslverr`  out  1  error response; valid only when `pready`=1.

## Operation
- BYTES = DATA_WIDTH/8, LSB = log2(BYTES), index = `paddr[ADDR_WIDTH-1:LSB]`.
- Error condition `err` = `paddr[LSB-1:0]` != 0 (misaligned) or index >= DEPTH.
- States: IDLE, ACCESS. A cycle counter `cnt` is 4 bits wide.
- IDLE: on `psel`=1, `penable`=0 (SETUP), the block captures `pwrite`, index, `pwdata`, `pstrb` and `err`. It loads `cnt` with WAIT_STATES. For a read, it loads `prdata` with mem[index], or with 0 if `err`. It then moves to ACCESS.
- ACCESS, `psel`=1 and `penable`=1:
  - If `cnt` != 0, decrement `cnt`; `pready`=0.
  - If `cnt` = 0, `pready`=1 and the transfer completes. A write without `err` updates each byte lane i where `pstrb[i]`=1. The next state is IDLE.
- ACCESS with `psel`=0 (aborted transfer): go to IDLE, no write, `pready` stays 0.
- `pready` = (state==ACCESS && `cnt`==0 && `psel` && `penable`), decoded from flops plus the inputs.
- `pslverr` = `pready` && captured `err`; 0 at all other times.
- An erroring write leaves memory untouched. An erroring read returns `prdata`=0.
- A write with `pstrb`=0 completes with OKAY and leaves memory unchanged.
- `prdata` holds its last value until the next read SETUP; writes do not change it.
- Memory contents are not reset. Reads of never-written locations return X in simulation.

## Timing
- Reset (`presetn`=0, immediate, asynchronous): state=IDLE, `cnt`=0, `prdata`=0, `pready`=0, `pslverr`=0, capture registers=0.
- Reset asserted mid-transfer: the transfer is dropped, no memory write occurs, and outputs go to their reset values in the same cycle.
- Transfer length = 2 + WAIT_STATES cycles, SETUP to completion inclusive. With WAIT_STATES=0, `pready`=1 in the first ACCESS cycle.
- Back-to-back transfers: the completion cycle is followed directly by the next SETUP with no idle cycle. The IDLE state accepts that SETUP, so throughput is one transfer per 2+WAIT_STATES cycles.
- Read-after-write to the same word: the read SETUP follows the write completion edge, so it returns the new data.
- `penable`=1 seen in IDLE (no SETUP) is a protocol error: it is ignored and the block stays in IDLE with `pready`=0.
- Address or data changes during ACCESS are ignored, because the SETUP-cycle capture is used.

## Test plan
- Reset then basic write/read, DATA_WIDTH=32, WAIT_STATES=1: write 0xDEADBEEF to 0x10 with `pstrb`=0xF, then read 0x10 -> `prdata`=0xDEADBEEF, `pslverr`=0, `pready` high exactly in cycle 3 of each transfer.
- Byte strobes: write 0x11223344 to 0x20 with `pstrb`=0xF, then write 0xAABBCCDD with `pstrb`=0x5 -> read returns 0x11BB33DD.
- Errors, DEPTH=256: write to 0x400 (index 256) and to 0x13 (misaligned) -> `pslverr`=1 with `pready`. A following read of 0x13 returns `prdata`=0 and `pslverr`=1. Memory at 0x10 is unchanged.
- Wait states: WAIT_STATES=0 gives `pready` in cycle 2. WAIT_STATES=3 gives `pready` in cycle 5. Back-to-back 30 random transfers against a scoreboard match with no idle cycles inserted.
- Abort and reset: drop `psel` in the first ACCESS cycle of a write to 0x30 -> no write and `pready` never asserted. Assert `presetn`=0 mid-read -> `prdata`, `pready` and `pslverr` go to 0 immediately, and the next transfer after reset completes normally.
